datapath_p2: RTL and testbench
==============================

# datapath_p2

Bus-based 32-bit datapath for the Phase-2 mini-RISC CPU. It contains the 16×32 general register file with Gra/Grb/Grc select-and-encode, PC, IR, MAR, MDR, Y, Z, HI, LO, in/out ports and a CON branch flip-flop. It also includes a 512×32 word-addressed RAM and a small ALU. The external control unit (or testbench FSM) drives all control strobes; this block performs only register transfers.

## Interface
Parameters:
- MEM_WORDS, 512, RAM depth (MAR uses the low 9 bits).

Ports, in instantiation order:
- Clock  in  1  single system clock; all state updates on the rising edge.
- Clear  in  1  reset, asynchronous, active-low.
- outp  out  32  OutPort register contents.
- BranchMet  out  1  CON flip-flop output.
- PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout  in  1 each  bus source enables.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin  in  1 each  register load enables.
- IncPC  in  1  ALU computes bus+1.
- Read  in  1  MDR source = Mdatain.
- Write  in  1  RAM[MAR] ← MDR.
- ReadEn  in  1  MDR source = RAM[MAR].
- Gra, Grb, Grc  in  1 each  register select from IR.
- Rin, Rout, BAout  in  1 each  selected-register write, read and base-address read.
- Cout  in  1  sign-extended IR[18:0] onto the bus.
- CONIn  in  1  latch the branch condition.
- Strobe  in  1  InPort ← InPort_data.
- Mdatain  in  32  external memory data.
- InPort_data  in  32  external input device data.
- AND, OR, ADD  in  1 each  ALU operation selects.

## Operation
- Bus: exactly one source is expected. Priority if several are asserted: Rout/BAout, then PCout, MDRout, Zhiout, Zlowout, HIout, LOout, InPortout, Cout. With no source asserted, bus = 0.
- Register select: Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
  - The selected index is the OR of the Gra/Grb/Grc-gated fields.
  - Rin writes the bus into R[sel].
  - Rout drives R[sel] onto the bus.
  - BAout drives R[sel] onto the bus, except that R0 reads as 0.
- C = {{13{IR[18]}}, IR[18:0]}.
- ALU (A = Y, B = bus), 64-bit result into Z:
  - Priority: IncPC (Zlo = B+1), then ADD (A+B), OR, AND.
  - With no op asserted, Zlo = B.
  - Zhi = 0 for all these ops.
- Z loads on Zin.
- MDR input mux: Read selects Mdatain, ReadEn selects RAM[MAR[8:0]] (combinational read), otherwise the bus. MDR loads on MDRin. If Read and ReadEn are both set, Read wins.
- RAM write: synchronous, RAM[MAR[8:0]] ← MDR when Write = 1.
- CON: on CONIn, BranchMet ← condition on the bus, selected by IR[20:19]:
  - 00: bus == 0
  - 01: bus != 0
  - 10: bus[31] = 0 and bus != 0
  - 11: bus[31] = 1
- OutPort loads the bus on OutPortin; outp = OutPort.
- InPort loads InPort_data on Strobe.

## Timing
- Every register and RAM write takes effect at the rising Clock edge on which its enable is high; the result is visible on the bus one cycle later.
- Bus, ALU, select logic and the RAM read path are purely combinational.
- Reset: Clear = 0 asynchronously zeroes R0–R15, PC, IR, MAR, MDR, Y, Z, HI, LO, InPort, OutPort and CON. As a result outp = 0 and BranchMet = 0.
- RAM contents are not reset.
- A reset asserted mid-sequence aborts all pending loads; nothing loads while Clear = 0.
- A simultaneous load and read of the same register yields the old value on the bus; the new value is stored at the edge.

## Test plan
- RAM preload:
  - Mdatain = 85 with Read+MDRin, then MDRout+MARin, then Mdatain = 34 with Read+MDRin, then MDRout+Write.
  - Required: RAM[85] = 34.
- Register preload:
  - IR = 0x00800000 with 10 via MDRout+Gra+Rin gives R1 = 10.
  - IR = 0 with 0 via MDRout+Gra+Rin gives R0 = 0.
- ld R1,85(R0) with PC = 0:
  - T0 PCout+MARin+IncPC+Zin gives Z = 1. T1 Zlowout+PCin gives PC = 1.
  - IR = 0x00800055. Grb+BAout+Yin gives Y = 0.
  - Cout+ADD+Zin gives Z = 85. Zlowout+MARin gives MAR = 85.
  - ReadEn+MDRin gives MDR = 34. MDRout+Gra+Rin gives R1 = 34.
- BAout on R0 after loading R0 = 7: bus = 0. With Rout instead: bus = 7.
- CON: IR[20:19] = 01 with bus = 5 and CONIn gives BranchMet = 1. With bus = 0, BranchMet = 0.
- I/O and reset:
  - Strobe with InPort_data = 0xA5, then InPortout+OutPortin, gives outp = 0xA5.
  - Clear = 0 mid-cycle gives outp = 0 immediately.

Source files
------------

// File: rtl/datapath_p2_if.sv
// Control strobes, data inputs and observable outputs of the Phase-2 datapath.
// The control unit or bench drives the master side. The datapath is the slave.
interface datapath_p2_if;
    logic [31:0] outp;
    logic        BranchMet;
    logic        PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin;
    logic        IncPC, Read, Write, ReadEn;
    logic        Gra, Grb, Grc;
    logic        Rin, Rout, BAout;
    logic        Cout, CONIn, Strobe;
    logic [31:0] Mdatain;
    logic [31:0] InPort_data;
    logic        AND, OR, ADD;

    modport master (
        input  outp, BranchMet,
        output PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin,
        output IncPC, Read, Write, ReadEn, Gra, Grb, Grc, Rin, Rout, BAout,
        output Cout, CONIn, Strobe, Mdatain, InPort_data, AND, OR, ADD
    );

    modport slave (
        output outp, BranchMet,
        input  PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin,
        input  IncPC, Read, Write, ReadEn, Gra, Grb, Grc, Rin, Rout, BAout,
        input  Cout, CONIn, Strobe, Mdatain, InPort_data, AND, OR, ADD
    );
endinterface

// File: rtl/datapath_p2.sv
// Single-bus 32-bit datapath for the Phase-2 mini-RISC CPU: register file, special
// registers, word-addressed RAM, small ALU and branch-condition flip-flop.
module datapath_p2 #(
    parameter int MEM_WORDS = 512
) (
    input logic          Clock,
    input logic          Clear,
    datapath_p2_if.slave dp
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   r [16];
    logic [31:0]   pc, mdr, y, z_hi, z_lo, hi, lo, in_port, out_port;
    // Only the IR fields and MAR bits that feed logic are kept.
    logic [26:0]   ir;
    logic [AW-1:0] mar;
    logic          con;
    logic [31:0]   mem [MEM_WORDS];

    logic [3:0]    sel;
    logic [31:0]   reg_val, c_val, ram_q, bus, alu_lo, mdr_d;
    logic          cond;

    assign sel     = ({4{dp.Gra}} & ir[26:23]) | ({4{dp.Grb}} & ir[22:19]) |
                     ({4{dp.Grc}} & ir[18:15]);
    assign reg_val = r[sel];
    assign c_val   = {{13{ir[18]}}, ir[18:0]};
    assign ram_q   = mem[mar];

    always_comb begin
        bus = '0;
        if (dp.Rout)           bus = reg_val;
        else if (dp.BAout)     bus = (sel == 4'd0) ? '0 : reg_val;
        else if (dp.PCout)     bus = pc;
        else if (dp.MDRout)    bus = mdr;
        else if (dp.Zhiout)    bus = z_hi;
        else if (dp.Zlowout)   bus = z_lo;
        else if (dp.HIout)     bus = hi;
        else if (dp.LOout)     bus = lo;
        else if (dp.InPortout) bus = in_port;
        else if (dp.Cout)      bus = c_val;
    end

    always_comb begin
        alu_lo = bus;
        if (dp.IncPC)    alu_lo = bus + 32'd1;
        else if (dp.ADD) alu_lo = y + bus;
        else if (dp.OR)  alu_lo = y | bus;
        else if (dp.AND) alu_lo = y & bus;
    end

    always_comb begin
        mdr_d = bus;
        if (dp.Read)        mdr_d = dp.Mdatain;
        else if (dp.ReadEn) mdr_d = ram_q;
    end

    always_comb begin
        cond = 1'b0;
        case (ir[20:19])
            2'b00: cond = (bus == 32'd0);
            2'b01: cond = (bus != 32'd0);
            2'b10: cond = !bus[31] && (bus != 32'd0);
            2'b11: cond = bus[31];
            default: cond = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < 16; i++) r[i] <= '0;
        end else if (dp.Rin) begin
            r[sel] <= bus;
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            pc       <= '0;
            ir       <= '0;
            mar      <= '0;
            mdr      <= '0;
            y        <= '0;
            z_hi     <= '0;
            z_lo     <= '0;
            hi       <= '0;
            lo       <= '0;
            in_port  <= '0;
            out_port <= '0;
            con      <= 1'b0;
        end else begin
            if (dp.PCin)      pc       <= bus;
            if (dp.IRin)      ir       <= bus[26:0];
            if (dp.MARin)     mar      <= bus[AW-1:0];
            if (dp.MDRin)     mdr      <= mdr_d;
            if (dp.Yin)       y        <= bus;
            if (dp.HIin)      hi       <= bus;
            if (dp.LOin)      lo       <= bus;
            if (dp.Strobe)    in_port  <= dp.InPort_data;
            if (dp.OutPortin) out_port <= bus;
            if (dp.CONIn)     con      <= cond;
            // None of the supported ALU ops produce upper-half results.
            if (dp.Zin) begin
                z_hi <= '0;
                z_lo <= alu_lo;
            end
        end
    end

    // RAM has no reset; writes are still held off while Clear is low.
    always_ff @(posedge Clock) begin
        if (dp.Write && Clear) mem[mar] <= mdr;
    end

    assign dp.outp      = out_port;
    assign dp.BranchMet = con;
endmodule

// File: tb/tb_datapath_p2.sv
// Directed bench for datapath_p2: the internal bus is observed by copying it into
// OutPort, and each result is compared with a hand-computed value.
module tb_datapath_p2;
  logic Clock = 1'b0;
  logic Clear = 1'b0;
  int   total = 0;
  int   bad   = 0;

  datapath_p2_if dp ();

  datapath_p2 #(.MEM_WORDS(512)) dut (
    .Clock (Clock),
    .Clear (Clear),
    .dp    (dp.slave)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clr_ctl();
    dp.PCout = 0; dp.Zhiout = 0; dp.Zlowout = 0; dp.MDRout = 0; dp.HIout = 0;
    dp.LOout = 0; dp.InPortout = 0; dp.MARin = 0; dp.Zin = 0; dp.PCin = 0;
    dp.MDRin = 0; dp.IRin = 0; dp.Yin = 0; dp.HIin = 0; dp.LOin = 0;
    dp.OutPortin = 0; dp.IncPC = 0; dp.Read = 0; dp.Write = 0; dp.ReadEn = 0;
    dp.Gra = 0; dp.Grb = 0; dp.Grc = 0; dp.Rin = 0; dp.Rout = 0; dp.BAout = 0;
    dp.Cout = 0; dp.CONIn = 0; dp.Strobe = 0; dp.AND = 0; dp.OR = 0; dp.ADD = 0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    clr_ctl();
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Caller selects the bus source first; this copies the bus into OutPort.
  task automatic show(input string tag, input logic [31:0] exp);
    dp.OutPortin = 1;
    step();
    check_eq(tag, dp.outp, exp);
  endtask

  task automatic mdr_load(input logic [31:0] v);
    dp.Mdatain = v; dp.Read = 1; dp.MDRin = 1;
    step();
  endtask

  task automatic ir_load(input logic [31:0] v);
    mdr_load(v);
    dp.MDRout = 1; dp.IRin = 1;
    step();
  endtask

  task automatic con_test(input string tag, input logic [31:0] irv,
                          input logic [31:0] busv, input logic exp);
    ir_load(irv);
    mdr_load(busv);
    dp.MDRout = 1; dp.CONIn = 1;
    step();
    check_eq(tag, {31'd0, dp.BranchMet}, {31'd0, exp});
  endtask

  initial begin
    clr_ctl();
    dp.Mdatain = '0;
    dp.InPort_data = '0;
    repeat (2) @(posedge Clock);
    #1;
    check_eq("rst_outp", dp.outp, 32'd0);
    check_eq("rst_branch", {31'd0, dp.BranchMet}, 32'd0);
    Clear = 1'b1;

    // RAM[85] = 34
    mdr_load(32'd85);
    dp.MDRout = 1; show("mdr_85", 32'd85);
    dp.MDRout = 1; dp.MARin = 1; step();
    mdr_load(32'd34);
    dp.MDRout = 1; dp.Write = 1; step();

    // R1 = 10, R0 = 0
    ir_load(32'h0080_0000);
    mdr_load(32'd10);
    dp.MDRout = 1; dp.Gra = 1; dp.Rin = 1; step();
    dp.Gra = 1; dp.Rout = 1; show("r1_10", 32'd10);
    ir_load(32'h0000_0000);
    mdr_load(32'd0);
    dp.MDRout = 1; dp.Gra = 1; dp.Rin = 1; step();
    dp.Gra = 1; dp.Rout = 1; show("r0_0", 32'd0);

    // ld R1,85(R0)
    dp.PCout = 1; dp.MARin = 1; dp.IncPC = 1; dp.Zin = 1; step();
    dp.Zlowout = 1; show("t0_zlo", 32'd1);
    dp.Zhiout = 1; show("t0_zhi", 32'd0);
    dp.Zlowout = 1; dp.PCin = 1; step();
    dp.PCout = 1; show("t1_pc", 32'd1);
    ir_load(32'h0080_0055);
    dp.Grb = 1; dp.BAout = 1; dp.Yin = 1; step();
    dp.Cout = 1; dp.ADD = 1; dp.Zin = 1; step();
    dp.Zlowout = 1; show("ld_ea", 32'd85);
    dp.Zlowout = 1; dp.MARin = 1; step();
    dp.ReadEn = 1; dp.MDRin = 1; step();
    dp.MDRout = 1; show("ld_mdr", 32'd34);
    dp.MDRout = 1; dp.Gra = 1; dp.Rin = 1; step();
    dp.Gra = 1; dp.Rout = 1; show("ld_r1", 32'd34);

    // ALU with Y = 34, B = C = 85
    dp.MDRout = 1; dp.Yin = 1; step();
    dp.Cout = 1; dp.ADD = 1; dp.Zin = 1; step();
    dp.Zlowout = 1; show("alu_add", 32'd119);
    dp.Cout = 1; dp.OR = 1; dp.Zin = 1; step();
    dp.Zlowout = 1; show("alu_or", 32'h77);
    dp.Cout = 1; dp.AND = 1; dp.Zin = 1; step();
    dp.Zlowout = 1; show("alu_and", 32'h00);
    dp.Cout = 1; dp.Zin = 1; step();
    dp.Zlowout = 1; show("alu_pass", 32'd85);
    dp.Cout = 1; dp.IncPC = 1; dp.ADD = 1; dp.Zin = 1; step();
    dp.Zlowout = 1; show("alu_inc_prio", 32'd86);
    ir_load(32'h0004_0000);
    dp.Cout = 1; show("c_sext", 32'hFFFC_0000);

    // MDR mux priority, load/read overlap, empty bus, HI/LO
    dp.Mdatain = 32'd77; dp.Read = 1; dp.ReadEn = 1; dp.MDRin = 1; step();
    dp.MDRout = 1; show("read_prio", 32'd77);
    dp.Mdatain = 32'd99; dp.Read = 1; dp.MDRin = 1; dp.MDRout = 1;
    show("old_on_bus", 32'd77);
    dp.MDRout = 1; show("new_stored", 32'd99);
    show("no_source", 32'd0);
    dp.MDRout = 1; dp.HIin = 1; step();
    mdr_load(32'd3);
    dp.MDRout = 1; dp.LOin = 1; step();
    dp.HIout = 1; show("hi", 32'd99);
    dp.LOout = 1; show("lo", 32'd3);

    // BAout vs Rout on R0
    ir_load(32'h0000_0000);
    mdr_load(32'd7);
    dp.MDRout = 1; dp.Gra = 1; dp.Rin = 1; step();
    dp.Gra = 1; dp.BAout = 1; show("ba_r0", 32'd0);
    dp.Gra = 1; dp.Rout = 1; show("rout_r0", 32'd7);

    // CON conditions
    con_test("con_nz_5", 32'h0008_0000, 32'd5, 1'b1);
    con_test("con_nz_0", 32'h0008_0000, 32'd0, 1'b0);
    con_test("con_z_0", 32'h0000_0000, 32'd0, 1'b1);
    con_test("con_neg", 32'h0018_0000, 32'h8000_0000, 1'b1);
    con_test("con_pos_neg", 32'h0010_0000, 32'h8000_0000, 1'b0);
    con_test("con_pos_5", 32'h0010_0000, 32'd5, 1'b1);

    // I/O, then asynchronous clear mid-cycle
    dp.InPort_data = 32'hA5; dp.Strobe = 1; step();
    dp.InPortout = 1; show("io_a5", 32'hA5);
    #3;
    Clear = 1'b0;
    #1;
    check_eq("clr_outp", dp.outp, 32'd0);
    check_eq("clr_branch", {31'd0, dp.BranchMet}, 32'd0);
    mdr_load(32'd55);
    Clear = 1'b1;
    dp.MDRout = 1; show("clr_no_load", 32'd0);
    dp.PCout = 1; show("clr_pc", 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
